// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode constants
// ({cpol,cpha}) for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    DONE
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: host request/response plus SPI pins.
// master = controller side, slave = host/bus-model side.
interface spi_master_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 2
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  start;
  logic [CSW-1:0]        cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  spi_clk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_CS-1:0]     cs;

  modport master (
    input  start, cs_sel, cpol, cpha,
    input  tx_data, miso,
    output rx_data, busy, done,
    output spi_clk, mosi, cs
  );

  modport slave (
    output start, cs_sel, cpol, cpha,
    output tx_data, miso,
    input  rx_data, busy, done,
    input  spi_clk, mosi, cs
  );
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV half-period divider; ports clk, reset, en,
// idle_lvl in; spi_clk level and leading/trailing edge strobes out.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic idle_lvl,
  output logic spi_clk,
  output logic leading_edge,
  output logic trailing_edge
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  // Strobes flag the cycle whose closing edge toggles spi_clk,
  // so the controller acts on the same edge the slave sees.
  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));
  assign leading_edge  = tick && (sclk_q == idle_lvl);
  assign trailing_edge = tick && (sclk_q != idle_lvl);
  assign spi_clk = sclk_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = idle_lvl;
    if (en) begin
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
      sclk_d = tick ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master, modes 0-3, NUM_CS selects.
// Ports: clk, reset (sync, high), bus (master modport).
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CS     = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_multi_if.master bus
);
  import spi_pkg::*;

  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int XFER_LEN = 2 * DATA_WIDTH * CLK_DIV;
  localparam int CNTW = $clog2(XFER_LEN);

  spi_state_e            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [CSW-1:0]        cs_sel_q, cs_sel_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_CS-1:0]     cs_q, cs_d;

  logic accept;
  logic sclk, lead_e, trail_e;
  logic shift_ev, samp_ev;

  assign accept = (state_q == IDLE) && bus.start;

  // Kept out of the main comb block: the clock
  // generator's idle level depends on cpol_d.
  assign cpol_d   = accept ? bus.cpol : cpol_q;
  assign cpha_d   = accept ? bus.cpha : cpha_q;
  assign cs_sel_d = accept ? bus.cs_sel : cs_sel_q;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .reset        (reset),
    .en           (state_q == XFER),
    .idle_lvl     (cpol_d),
    .spi_clk      (sclk),
    .leading_edge (lead_e),
    .trailing_edge(trail_e)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNTW'(1);
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    shift_ev = cpha_q ? lead_e : trail_e;
    samp_ev  = cpha_q ? trail_e : lead_e;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        mosi_d = 1'b0;
        if (bus.start) begin
          state_d = LEAD;
          busy_d  = 1'b1;
          // CPHA=0 presents the MSB before the first edge;
          // CPHA=1 shifts it out on the first leading edge.
          if (bus.cpha) begin
            tx_sh_d = bus.tx_data;
          end else begin
            mosi_d  = bus.tx_data[DATA_WIDTH-1];
            tx_sh_d = bus.tx_data << 1;
          end
        end
      end
      LEAD: begin
        if (cnt_q == CNTW'(CLK_DIV - 1)) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (shift_ev) begin
          mosi_d  = tx_sh_q[DATA_WIDTH-1];
          tx_sh_d = tx_sh_q << 1;
        end
        if (samp_ev) begin
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], bus.miso};
        end
        if (cnt_q == CNTW'(XFER_LEN - 1)) begin
          state_d = TRAIL;
          cnt_d   = '0;
        end
      end
      TRAIL: begin
        if (cnt_q == CNTW'(CLK_DIV - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Out-of-range selects match no bit, so all lines stay high.
    cs_d = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if ((state_d inside {LEAD, XFER, TRAIL}) &&
          (32'(cs_sel_d) == i)) begin
        cs_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      cs_sel_q <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rx_q     <= '0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      cs_sel_q <= cs_sel_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
    end
  end

  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.spi_clk = sclk;
  assign bus.mosi    = mosi_q;
  assign bus.cs      = cs_q;
endmodule
